// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the multicycle MIPS control path:
//   opcode_e / funct_e  : instruction fields decoded by the controller
//   alu_op_e            : 3-bit ALU control codes driven to the datapath
//   alu_src_b_e         : ALU B-operand mux encodings
//   pc_src_e            : PC source mux encodings
//   mc_state_e          : controller FSM states
//   mc_ctrl_t           : bundle of every FSM output before final gating
// Optional build macro: MIPS_JAL_EN adds the JAL opcode constant and makes it
// a legal opcode.
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [5:0] {
        OP_R_TYPE = 6'h00,
        OP_J      = 6'h02,
        OP_BEQ    = 6'h04,
        OP_ADDI   = 6'h08,
        OP_LW     = 6'h23,
        OP_SW     = 6'h2B
    } opcode_e;

`ifdef MIPS_JAL_EN
    localparam logic [5:0] JAL = 6'h03;
`endif

    typedef enum logic [5:0] {
        F_ADD = 6'h20,
        F_SUB = 6'h22,
        F_AND = 6'h24,
        F_OR  = 6'h25,
        F_SLT = 6'h2A
    } funct_e;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_B       = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_e;

    // Coarse ALU request from the FSM, refined by mips_alu_dec.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_HALT   = 4'd13
    } mc_state_e;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_e alu_src_b;
        logic [1:0] alu_op;
        pc_src_e    pc_src;
        logic       link;
        logic       illegal_op;
        logic       instr_done;
    } mc_ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_R_TYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
`ifdef MIPS_JAL_EN
            JAL:                                            ok = 1'b1;
`endif
            default:                                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic funct_legal(input logic [5:0] fn);
        logic ok;
        case (fn)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: ok = 1'b1;
            default:                          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// -----------------------------------------------------------------------------
// mips_alu_dec
// Combinational ALU control decoder.
//   alu_op_i        [1:0] coarse request: 00 = ADD, 01 = SUB, 10 = use funct
//   funct_i         [5:0] IR[5:0]
//   alu_ctrl_o      [2:0] alu_op_e code for the ALU
//   funct_illegal_o       funct not recognised while alu_op_i selects funct
// -----------------------------------------------------------------------------
module mips_alu_dec
    import mips_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       funct_illegal_o
);

    always_comb begin
        alu_ctrl_o      = ALU_ADD;
        funct_illegal_o = 1'b0;
        case (alu_op_i)
            ALUOP_ADD: alu_ctrl_o = ALU_ADD;
            ALUOP_SUB: alu_ctrl_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    F_ADD:   alu_ctrl_o = ALU_ADD;
                    F_SUB:   alu_ctrl_o = ALU_SUB;
                    F_AND:   alu_ctrl_o = ALU_AND;
                    F_OR:    alu_ctrl_o = ALU_OR;
                    F_SLT:   alu_ctrl_o = ALU_SLT;
                    default: funct_illegal_o = 1'b1;
                endcase
            end
            default:   alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// -----------------------------------------------------------------------------
// mips_mc_ctrl
// Moore-style control FSM for the multicycle MIPS datapath (shared memory,
// single ALU). Steps each instruction through fetch/decode/execute/memory/
// writeback and stalls on mem_ready_i.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_FETCH  | read instruction at PC, PC+4 -> PC when memory is ready
// S_DECODE | read registers, precompute branch target into ALUOut
// S_MEMADR | compute effective address for LW/SW
// S_MEMRD  | memory read at ALUOut, wait for mem_ready
// S_MEMWB  | write MDR to rt
// S_MEMWR  | memory write at ALUOut, held until mem_ready
// S_EXEC   | R-type ALU operation selected by funct
// S_ALUWB  | write ALUOut to rd
// S_BRANCH | compare A-B, take branch target if zero
// S_ADDIEX | A + sign-extended immediate
// S_ADDIWB | write ALUOut to rt
// S_JUMP   | load jump target into PC
// S_JAL    | load jump target, write PC into r31 (MIPS_JAL_EN only)
// S_HALT   | illegal opcode trap, left only by reset
//
// Ports:
//   clk_i, rst_i (async active-high), opcode_i, funct_i, zero_i, mem_ready_i
//   pc_en_o, iord_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
//   reg_write_o, alu_src_a_o, alu_src_b_o[1:0], alu_ctrl_o[2:0],
//   pc_src_o[1:0], link_o, illegal_op_o, instr_done_o
// Parameters: RESET_STATE, ILLEGAL_TRAP.
// Optional build macro: MIPS_JAL_EN enables the JAL instruction; without it
// JAL decodes as illegal and link_o stays 0.
// -----------------------------------------------------------------------------
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter mc_state_e RESET_STATE  = S_FETCH,
    parameter bit        ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_en_o,
    output logic       iord_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_ctrl_o,
    output logic [1:0] pc_src_o,
    output logic       link_o,
    output logic       illegal_op_o,
    output logic       instr_done_o
);

    mc_state_e state_q, state_d;
    mc_ctrl_t  ctrl;
    logic      funct_illegal;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= RESET_STATE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                if (!op_legal(opcode_i)) begin
                    state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
                end else begin
                    case (opcode_i)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_R_TYPE:    state_d = S_EXEC;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
`ifdef MIPS_JAL_EN
                        JAL:          state_d = S_JAL;
`endif
                        default:      state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: state_d = (opcode_i == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready_i) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_JAL:    state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl           = '0;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready_i;
                ctrl.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH2;
                ctrl.illegal_op = !op_legal(opcode_i);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord       = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = mem_ready_i;
            end
            S_EXEC: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_op     = ALUOP_FUNCT;
                ctrl.illegal_op = funct_illegal;
            end
            S_ALUWB: begin
                // funct is still held from decode, so re-check it here
                // rather than carrying a flag out of S_EXEC.
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = funct_legal(funct_i);
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.pc_src     = PCSRC_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`ifdef MIPS_JAL_EN
            S_JAL: begin
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.link       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`endif
            default: ;
        endcase

        // Reset forces the state to RESET_STATE asynchronously; the strobes
        // are also cut here so nothing leaks out while rst_i is high.
        if (rst_i) begin
            ctrl.pc_write   = 1'b0;
            ctrl.branch     = 1'b0;
            ctrl.ir_write   = 1'b0;
            ctrl.mem_write  = 1'b0;
            ctrl.reg_write  = 1'b0;
            ctrl.link       = 1'b0;
            ctrl.illegal_op = 1'b0;
            ctrl.instr_done = 1'b0;
        end
    end

    mips_alu_dec u_alu_dec (
        .alu_op_i        (ctrl.alu_op),
        .funct_i         (funct_i),
        .alu_ctrl_o      (alu_ctrl_o),
        .funct_illegal_o (funct_illegal)
    );

    assign pc_en_o      = ctrl.pc_write | (ctrl.branch & zero_i);
    assign iord_o       = ctrl.iord;
    assign mem_write_o  = ctrl.mem_write;
    assign ir_write_o   = ctrl.ir_write;
    assign reg_dst_o    = ctrl.reg_dst;
    assign mem_to_reg_o = ctrl.mem_to_reg;
    assign reg_write_o  = ctrl.reg_write;
    assign alu_src_a_o  = ctrl.alu_src_a;
    assign alu_src_b_o  = ctrl.alu_src_b;
    assign pc_src_o     = ctrl.pc_src;
    assign link_o       = ctrl.link;
    assign illegal_op_o = ctrl.illegal_op;
    assign instr_done_o = ctrl.instr_done;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_mc_ctrl
// Table-driven bench for mips_mc_ctrl. Two instances share all inputs: one
// with default parameters, one with ILLEGAL_TRAP=1 for the halt sequence.
// -----------------------------------------------------------------------------
module tb_mips_mc_ctrl;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_src;
        logic       link;
        logic       illegal_op;
        logic       instr_done;
    } out_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       mr;
        out_t       exp;
        string      nm;
    } vec_t;

    //                         pc ior mw irw rd m2r rw sa  srcb   alu     psrc  lk ill dn
    localparam out_t E_RST    = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0, 0, 0};
    localparam out_t E_FETCH  = '{1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0, 0, 0};
    localparam out_t E_DEC    = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0, 0, 0};
    localparam out_t E_DECILL = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0, 1, 0};
    localparam out_t E_EXADD  = '{0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 2'b00, 0, 0, 0};
    localparam out_t E_EXSUB  = '{0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b00, 0, 0, 0};
    localparam out_t E_EXAND  = '{0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b000, 2'b00, 0, 0, 0};
    localparam out_t E_EXOR   = '{0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b00, 0, 0, 0};
    localparam out_t E_EXSLT  = '{0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b111, 2'b00, 0, 0, 0};
    localparam out_t E_EXILL  = '{0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 2'b00, 0, 1, 0};
    localparam out_t E_ALUWB  = '{0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0, 0, 1};
    localparam out_t E_ALUWBN = '{0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 0, 1};
    localparam out_t E_MEMADR = '{0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0, 0};
    localparam out_t E_MEMRD  = '{0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 0, 0};
    localparam out_t E_MEMWB  = '{0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b010, 2'b00, 0, 0, 1};
    localparam out_t E_MEMWRW = '{0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 0, 0};
    localparam out_t E_MEMWR  = '{0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 0, 1};
    localparam out_t E_BR1    = '{1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0, 0, 1};
    localparam out_t E_BR0    = '{0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0, 0, 1};
    localparam out_t E_ADDIWB = '{0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0, 0, 1};
    localparam out_t E_JUMP   = '{1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b10, 0, 0, 1};
    localparam out_t E_JAL    = '{1, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b010, 2'b10, 1, 0, 1};
    localparam out_t E_HALT   = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 0, 0};

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;

    logic       pc_en_a, iord_a, mw_a, irw_a, rd_a, m2r_a, rw_a, sa_a, lk_a, ill_a, dn_a;
    logic [1:0] sb_a, ps_a;
    logic [2:0] alu_a;
    logic       pc_en_t, iord_t, mw_t, irw_t, rd_t, m2r_t, rw_t, sa_t, lk_t, ill_t, dn_t;
    logic [1:0] sb_t, ps_t;
    logic [2:0] alu_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    out_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    mips_mc_ctrl dut_a (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct_i(funct),
        .zero_i(zero), .mem_ready_i(mem_ready),
        .pc_en_o(pc_en_a), .iord_o(iord_a), .mem_write_o(mw_a), .ir_write_o(irw_a),
        .reg_dst_o(rd_a), .mem_to_reg_o(m2r_a), .reg_write_o(rw_a),
        .alu_src_a_o(sa_a), .alu_src_b_o(sb_a), .alu_ctrl_o(alu_a),
        .pc_src_o(ps_a), .link_o(lk_a), .illegal_op_o(ill_a), .instr_done_o(dn_a)
    );

    mips_mc_ctrl #(.ILLEGAL_TRAP(1'b1)) dut_t (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct_i(funct),
        .zero_i(zero), .mem_ready_i(mem_ready),
        .pc_en_o(pc_en_t), .iord_o(iord_t), .mem_write_o(mw_t), .ir_write_o(irw_t),
        .reg_dst_o(rd_t), .mem_to_reg_o(m2r_t), .reg_write_o(rw_t),
        .alu_src_a_o(sa_t), .alu_src_b_o(sb_t), .alu_ctrl_o(alu_t),
        .pc_src_o(ps_t), .link_o(lk_t), .illegal_op_o(ill_t), .instr_done_o(dn_t)
    );

    function automatic out_t actual(input bit sel);
        if (sel)
            return {pc_en_t, iord_t, mw_t, irw_t, rd_t, m2r_t, rw_t, sa_t,
                    sb_t, alu_t, ps_t, lk_t, ill_t, dn_t};
        return {pc_en_a, iord_a, mw_a, irw_a, rd_a, m2r_a, rw_a, sa_a,
                sb_a, alu_a, ps_a, lk_a, ill_a, dn_a};
    endfunction

    task automatic chk(input string nm, input bit sel);
        out_t exp;
        out_t act;
        exp = sb.pop_front();
        act = actual(sel);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (dut %0d): got %b required %b", nm, sel, act, exp);
    endtask

    task automatic expect_now(input string nm, input bit sel, input out_t exp);
        sb.push_back(exp);
        chk(nm, sel);
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs are sampled
    // 3 units later, then the task waits for the next rising edge.
    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input logic mr, input out_t exp, input string nm, input bit sel);
        opcode    = op;
        funct     = fn;
        zero      = z;
        mem_ready = mr;
        sb.push_back(exp);
        #3;
        chk(nm, sel);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic mr, input out_t exp, input string nm);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.mr = mr; v.exp = exp; v.nm = nm;
        tbl.push_back(v);
    endtask

    initial begin
        // add $3,$1,$2 and other R-type functs
        add(6'h00, 6'h20, 0, 1, E_FETCH,  "add_fetch");
        add(6'h00, 6'h20, 0, 1, E_DEC,    "add_decode");
        add(6'h00, 6'h20, 0, 1, E_EXADD,  "add_exec");
        add(6'h00, 6'h20, 0, 1, E_ALUWB,  "add_aluwb");
        add(6'h00, 6'h22, 0, 1, E_FETCH,  "sub_fetch");
        add(6'h00, 6'h22, 0, 1, E_DEC,    "sub_decode");
        add(6'h00, 6'h22, 0, 1, E_EXSUB,  "sub_exec");
        add(6'h00, 6'h22, 0, 1, E_ALUWB,  "sub_aluwb");
        add(6'h00, 6'h24, 0, 1, E_FETCH,  "and_fetch");
        add(6'h00, 6'h24, 0, 1, E_DEC,    "and_decode");
        add(6'h00, 6'h24, 0, 1, E_EXAND,  "and_exec");
        add(6'h00, 6'h24, 0, 1, E_ALUWB,  "and_aluwb");
        add(6'h00, 6'h25, 0, 1, E_FETCH,  "or_fetch");
        add(6'h00, 6'h25, 0, 1, E_DEC,    "or_decode");
        add(6'h00, 6'h25, 0, 1, E_EXOR,   "or_exec");
        add(6'h00, 6'h25, 0, 1, E_ALUWB,  "or_aluwb");
        add(6'h00, 6'h2A, 0, 1, E_FETCH,  "slt_fetch");
        add(6'h00, 6'h2A, 0, 1, E_DEC,    "slt_decode");
        add(6'h00, 6'h2A, 0, 1, E_EXSLT,  "slt_exec");
        add(6'h00, 6'h2A, 0, 1, E_ALUWB,  "slt_aluwb");
        add(6'h00, 6'h3F, 0, 1, E_FETCH,  "badfn_fetch");
        add(6'h00, 6'h3F, 0, 1, E_DEC,    "badfn_decode");
        add(6'h00, 6'h3F, 0, 1, E_EXILL,  "badfn_exec");
        add(6'h00, 6'h3F, 0, 1, E_ALUWBN, "badfn_aluwb");
        // lw with two wait cycles in S_MEMRD: 7 cycles
        add(6'h23, 6'h00, 0, 1, E_FETCH,  "lw_fetch");
        add(6'h23, 6'h00, 0, 1, E_DEC,    "lw_decode");
        add(6'h23, 6'h00, 0, 1, E_MEMADR, "lw_memadr");
        add(6'h23, 6'h00, 0, 0, E_MEMRD,  "lw_memrd_w1");
        add(6'h23, 6'h00, 0, 0, E_MEMRD,  "lw_memrd_w2");
        add(6'h23, 6'h00, 0, 1, E_MEMRD,  "lw_memrd");
        add(6'h23, 6'h00, 0, 1, E_MEMWB,  "lw_memwb");
        // sw with a fetch stall and a write stall
        add(6'h2B, 6'h00, 0, 0, E_RST,    "sw_fetch_stall");
        add(6'h2B, 6'h00, 0, 1, E_FETCH,  "sw_fetch");
        add(6'h2B, 6'h00, 0, 1, E_DEC,    "sw_decode");
        add(6'h2B, 6'h00, 0, 1, E_MEMADR, "sw_memadr");
        add(6'h2B, 6'h00, 0, 0, E_MEMWRW, "sw_memwr_wait");
        add(6'h2B, 6'h00, 0, 1, E_MEMWR,  "sw_memwr");
        // beq taken / not taken
        add(6'h04, 6'h00, 1, 1, E_FETCH,  "beq1_fetch");
        add(6'h04, 6'h00, 1, 1, E_DEC,    "beq1_decode");
        add(6'h04, 6'h00, 1, 1, E_BR1,    "beq1_branch");
        add(6'h04, 6'h00, 0, 1, E_FETCH,  "beq0_fetch");
        add(6'h04, 6'h00, 0, 1, E_DEC,    "beq0_decode");
        add(6'h04, 6'h00, 0, 1, E_BR0,    "beq0_branch");
        // addi, j
        add(6'h08, 6'h00, 0, 1, E_FETCH,  "addi_fetch");
        add(6'h08, 6'h00, 0, 1, E_DEC,    "addi_decode");
        add(6'h08, 6'h00, 0, 1, E_MEMADR, "addi_ex");
        add(6'h08, 6'h00, 0, 1, E_ADDIWB, "addi_wb");
        add(6'h02, 6'h00, 0, 1, E_FETCH,  "j_fetch");
        add(6'h02, 6'h00, 0, 1, E_DEC,    "j_decode");
        add(6'h02, 6'h00, 0, 1, E_JUMP,   "j_jump");
        // illegal opcode returns to fetch
        add(6'h3F, 6'h00, 0, 1, E_FETCH,  "ill_fetch");
        add(6'h3F, 6'h00, 0, 1, E_DECILL, "ill_decode");
        // jal 0x0C000010
        add(6'h03, 6'h10, 0, 1, E_FETCH,  "jal_fetch");
`ifdef MIPS_JAL_EN
        add(6'h03, 6'h10, 0, 1, E_DEC,    "jal_decode");
        add(6'h03, 6'h10, 0, 1, E_JAL,    "jal_jal");
`else
        add(6'h03, 6'h10, 0, 1, E_DECILL, "jal_illegal");
`endif
        add(6'h00, 6'h20, 0, 1, E_FETCH,  "final_fetch");

        rst = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        #12;
        expect_now("reset_outputs", 0, E_RST);
        mem_ready = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) step(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].mr, tbl[i].exp, tbl[i].nm, 0);

        // ILLEGAL_TRAP=1: illegal opcode halts with all strobes low
        rst = 1'b1; mem_ready = 1'b0;
        #1;
        expect_now("trap_reset", 1, E_RST);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        step(6'h3F, 6'h00, 0, 1, E_FETCH,  "trap_fetch", 1);
        step(6'h3F, 6'h00, 0, 1, E_DECILL, "trap_decode", 1);
        expect_now("notrap_back_to_fetch", 0, E_FETCH);
        for (int k = 0; k < 10; k++) step(6'h00, 6'h20, 1, 1, E_HALT, $sformatf("trap_halt%0d", k), 1);

        // reset in S_MEMWR drops mem_write at once; fetch resumes cleanly
        rst = 1'b1; mem_ready = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        step(6'h2B, 6'h00, 0, 1, E_FETCH,  "swrst_fetch", 0);
        step(6'h2B, 6'h00, 0, 1, E_DEC,    "swrst_decode", 0);
        step(6'h2B, 6'h00, 0, 1, E_MEMADR, "swrst_memadr", 0);
        step(6'h2B, 6'h00, 0, 0, E_MEMWRW, "swrst_memwr", 0);
        rst = 1'b1;
        #1;
        expect_now("swrst_strobes_low", 0, E_RST);
        #1 rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        expect_now("swrst_fetch_after", 0, E_FETCH);
        @(posedge clk); #1;
        step(6'h2B, 6'h00, 0, 1, E_DEC,    "swrst_redecode", 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
